// File: rtl/key_pkg.sv
// Shared definitions for the key auto-repeat controller.
// Contents: scan-code constants for both key maps, command and FSM state
// enums, and helpers to decode a scan code and build one-hot pulses.
package key_pkg;

  // Player 0 key map: arrows / space / enter
  localparam logic [7:0] P0_LEFT   = 8'h6B;
  localparam logic [7:0] P0_RIGHT  = 8'h74;
  localparam logic [7:0] P0_DOWN   = 8'h72;
  localparam logic [7:0] P0_ROTATE = 8'h75;
  localparam logic [7:0] P0_DROP   = 8'h29;
  localparam logic [7:0] P0_PAUSE  = 8'h5A;

  // Player 1 key map: W/A/S/D / ctrl / shift
  localparam logic [7:0] P1_LEFT   = 8'h1C;
  localparam logic [7:0] P1_RIGHT  = 8'h23;
  localparam logic [7:0] P1_DOWN   = 8'h1B;
  localparam logic [7:0] P1_ROTATE = 8'h1D;
  localparam logic [7:0] P1_DROP   = 8'h14;
  localparam logic [7:0] P1_PAUSE  = 8'h12;

  localparam int CNT_W = 24;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_DOWN,
    CMD_ROTATE,
    CMD_DROP,
    CMD_PAUSE
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    DELAY,
    REPEAT,
    HOLD
  } state_t;

  // Map a scan code to a command for the selected player; anything
  // unmapped (including 00) is CMD_NONE, i.e. a release.
  function automatic cmd_t decode_key(input logic [7:0] code, input logic player);
    cmd_t cmd;
    cmd = CMD_NONE;
    if (!player) begin
      case (code)
        P0_LEFT:   cmd = CMD_LEFT;
        P0_RIGHT:  cmd = CMD_RIGHT;
        P0_DOWN:   cmd = CMD_DOWN;
        P0_ROTATE: cmd = CMD_ROTATE;
        P0_DROP:   cmd = CMD_DROP;
        P0_PAUSE:  cmd = CMD_PAUSE;
        default:   cmd = CMD_NONE;
      endcase
    end else begin
      case (code)
        P1_LEFT:   cmd = CMD_LEFT;
        P1_RIGHT:  cmd = CMD_RIGHT;
        P1_DOWN:   cmd = CMD_DOWN;
        P1_ROTATE: cmd = CMD_ROTATE;
        P1_DROP:   cmd = CMD_DROP;
        P1_PAUSE:  cmd = CMD_PAUSE;
        default:   cmd = CMD_NONE;
      endcase
    end
    return cmd;
  endfunction

  // Movement keys auto-repeat; rotate/drop/pause fire once per press.
  function automatic logic is_repeatable(input cmd_t cmd);
    return (cmd == CMD_LEFT) || (cmd == CMD_RIGHT) || (cmd == CMD_DOWN);
  endfunction

  // Bit order: {pause, drop, rotate, down, right, left}
  function automatic logic [5:0] cmd_onehot(input cmd_t cmd);
    logic [5:0] oh;
    oh = 6'b000000;
    case (cmd)
      CMD_LEFT:   oh = 6'b000001;
      CMD_RIGHT:  oh = 6'b000010;
      CMD_DOWN:   oh = 6'b000100;
      CMD_ROTATE: oh = 6'b001000;
      CMD_DROP:   oh = 6'b010000;
      CMD_PAUSE:  oh = 6'b100000;
      default:    oh = 6'b000000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Brings the asynchronous PS/2 held-key code into i_clk and filters it.
// Ports: i_clk, i_rst_n (sync, active-low), i_key[7:0] async in,
//        o_key_stable[7:0] code that survived two matching samples.
module key_sync (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_key,
  output logic [7:0] o_key_stable
);

  logic [7:0] r_s1;
  logic [7:0] r_s2;
  logic [7:0] r_s3;
  logic [7:0] r_key_stable;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1         <= 8'h00;
      r_s2         <= 8'h00;
      r_s3         <= 8'h00;
      r_key_stable <= 8'h00;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      // Only accept a code once two consecutive synchronized samples agree;
      // a one-sample glitch or mid-change value never propagates.
      if (r_s2 == r_s3) begin
        r_key_stable <= r_s2;
      end
    end
  end

  assign o_key_stable = r_key_stable;

endmodule

// File: rtl/key_repeat_ctrl.sv
// Turns a held PS/2 key into game command pulses with delayed auto-repeat.
// Ports: i_clk, i_rst_n (sync, active-low), i_key[7:0] held scan code;
//        o_left/o_right/o_down/o_rotate/o_drop/o_pause one-cycle pulses,
//        o_active high while a mapped key is being tracked.
module key_repeat_ctrl
  import key_pkg::*;
#(
  parameter int PLAYER     = 0,
  parameter int DAS_CYCLES = 8_000_000,
  parameter int ARR_CYCLES = 2_500_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_key,
  output logic       o_left,
  output logic       o_right,
  output logic       o_down,
  output logic       o_rotate,
  output logic       o_drop,
  output logic       o_pause,
  output logic       o_active
);

  localparam logic             PLAYER_SEL = (PLAYER != 0);
  localparam logic [CNT_W-1:0] DAS_LOAD   = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LOAD   = CNT_W'(ARR_CYCLES - 1);

  logic [7:0]       w_key_stable;
  cmd_t             w_key_cmd;
  cmd_t             w_cur_cmd;

  state_t           r_state;
  logic [7:0]       r_cur_code;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_pulse;
  logic             r_active;

  key_sync u_key_sync (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_key        (i_key),
    .o_key_stable (w_key_stable)
  );

  assign w_key_cmd = decode_key(w_key_stable, PLAYER_SEL);
  assign w_cur_cmd = decode_key(r_cur_code, PLAYER_SEL);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cur_code <= 8'h00;
      r_cnt      <= '0;
      r_pulse    <= 6'b000000;
      r_active   <= 1'b0;
    end else begin
      // Pulses are single-cycle: cleared unless this edge fires one.
      r_pulse <= 6'b000000;

      case (r_state)
        IDLE: begin
          if (w_key_cmd != CMD_NONE) begin
            r_state    <= FIRST;
            r_cur_code <= w_key_stable;
            r_pulse    <= cmd_onehot(w_key_cmd);
            // The FIRST cycle is counted as the first cycle of the hold
            // delay, so the second pulse lands exactly DAS_CYCLES after
            // the first one.
            r_cnt      <= DAS_LOAD;
            r_active   <= 1'b1;
          end
        end

        FIRST: begin
          if (is_repeatable(w_cur_cmd)) begin
            r_state <= DELAY;
            r_cnt   <= (r_cnt == '0) ? '0 : r_cnt - 1'b1;
          end else begin
            r_state <= HOLD;
          end
        end

        DELAY, REPEAT, HOLD: begin
          // A code change outranks an expiring counter: the old key must
          // not emit a final pulse once it has been released or replaced.
          if (w_key_stable != r_cur_code) begin
            if (w_key_cmd != CMD_NONE) begin
              r_state    <= FIRST;
              r_cur_code <= w_key_stable;
              r_pulse    <= cmd_onehot(w_key_cmd);
              r_cnt      <= DAS_LOAD;
              r_active   <= 1'b1;
            end else begin
              r_state    <= IDLE;
              r_cur_code <= 8'h00;
              r_cnt      <= '0;
              r_active   <= 1'b0;
            end
          end else if (r_state != HOLD) begin
            if (r_cnt == '0) begin
              r_state <= REPEAT;
              r_pulse <= cmd_onehot(w_cur_cmd);
              r_cnt   <= ARR_LOAD;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end

        default: begin
          r_state  <= IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_left   = r_pulse[0];
  assign o_right  = r_pulse[1];
  assign o_down   = r_pulse[2];
  assign o_rotate = r_pulse[3];
  assign o_drop   = r_pulse[4];
  assign o_pause  = r_pulse[5];
  assign o_active = r_active;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Self-checking bench for key_repeat_ctrl: one instance per player map,
// directed press scenarios plus randomized key/hold/reset sequences,
// all compared every cycle against a press-age reference model.
module tb_key_repeat_ctrl;

  localparam int DAS = 10;
  localparam int ARR = 4;

  // Key maps in output order {left,right,down,rotate,drop,pause}
  localparam logic [7:0] KEYMAP [2][6] = '{
    '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'h5A},
    '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h14, 8'h12}
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key;
  logic [5:0] out0, out1;
  logic       act0, act1;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_s1, m_s2, m_s3, m_stable;
  logic [7:0] m_code [2];
  int         m_age  [2];
  logic [5:0] m_exp  [2];
  logic       m_act  [2];

  // Observed pulse tallies for directed scenarios
  int  cnt0 [6];
  int  p1_pulses;
  bit  p1_active_seen;

  always #5 clk = ~clk;

  key_repeat_ctrl #(.PLAYER(0), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key),
    .o_left(out0[0]), .o_right(out0[1]), .o_down(out0[2]),
    .o_rotate(out0[3]), .o_drop(out0[4]), .o_pause(out0[5]),
    .o_active(act0)
  );

  key_repeat_ctrl #(.PLAYER(1), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key),
    .o_left(out1[0]), .o_right(out1[1]), .o_down(out1[2]),
    .o_rotate(out1[3]), .o_drop(out1[4]), .o_pause(out1[5]),
    .o_active(act1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 1..6 for a mapped key (output index + 1), 0 for release
  function automatic int cmd_idx(input logic [7:0] code, input int p);
    for (int i = 0; i < 6; i++) begin
      if (KEYMAP[p][i] == code) return i + 1;
    end
    return 0;
  endfunction

  // Advance the model by one clock edge. Each press is tracked by its age
  // (edges since the first pulse); pulse times follow from plain arithmetic.
  task automatic model_step(input logic r, input logic [7:0] k);
    logic [7:0] seen;
    int c, cc;
    if (!r) begin
      m_s1 = 8'h00; m_s2 = 8'h00; m_s3 = 8'h00; m_stable = 8'h00;
      for (int p = 0; p < 2; p++) begin
        m_code[p] = 8'h00; m_age[p] = 0; m_exp[p] = 6'b0; m_act[p] = 1'b0;
      end
    end else begin
      seen = m_stable;
      if (m_s2 == m_s3) m_stable = m_s2;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = k;
      for (int p = 0; p < 2; p++) begin
        c = cmd_idx(seen, p);
        m_exp[p] = 6'b0;
        if (m_code[p] == 8'h00) begin
          if (c != 0) begin
            m_code[p] = seen; m_age[p] = 0; m_exp[p] = 6'(1 << (c - 1));
          end
        end else if (m_age[p] >= 1 && seen != m_code[p]) begin
          if (c != 0) begin
            m_code[p] = seen; m_age[p] = 0; m_exp[p] = 6'(1 << (c - 1));
          end else begin
            m_code[p] = 8'h00;
          end
        end else begin
          m_age[p]++;
          cc = cmd_idx(m_code[p], p);
          if (cc >= 1 && cc <= 3 &&
              (m_age[p] == DAS || (m_age[p] > DAS && (m_age[p] - DAS) % ARR == 0)))
            m_exp[p] = 6'(1 << (cc - 1));
        end
        m_act[p] = (m_code[p] != 8'h00);
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] k);
    @(negedge clk);
    rst_n = r;
    key   = k;
    @(posedge clk);
    model_step(r, k);
    #1;
    check_eq("p0_cmd", {26'd0, out0}, {26'd0, m_exp[0]});
    check_eq("p0_active", {31'd0, act0}, {31'd0, m_act[0]});
    check_eq("p1_cmd", {26'd0, out1}, {26'd0, m_exp[1]});
    check_eq("p1_active", {31'd0, act1}, {31'd0, m_act[1]});
    for (int i = 0; i < 6; i++) cnt0[i] += int'(out0[i]);
    p1_pulses += $countones(out1);
    if (act1) p1_active_seen = 1'b1;
  endtask

  task automatic hold(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) step(1'b1, k);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 6; i++) cnt0[i] = 0;
  endtask

  task automatic check_counts(input string tag, input int l, input int r, input int d,
                              input int rot, input int drp, input int pau);
    check_eq({tag, "_left"},   cnt0[0], l);
    check_eq({tag, "_right"},  cnt0[1], r);
    check_eq({tag, "_down"},   cnt0[2], d);
    check_eq({tag, "_rotate"}, cnt0[3], rot);
    check_eq({tag, "_drop"},   cnt0[4], drp);
    check_eq({tag, "_pause"},  cnt0[5], pau);
  endtask

  initial begin
    logic [7:0] k;
    int r;
    rst_n = 1'b0;
    key   = 8'h00;
    p1_pulses = 0;
    p1_active_seen = 1'b0;
    clear_counts();

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    check_eq("rst_cmd0", {26'd0, out0}, 32'd0);
    check_eq("rst_act0", {31'd0, act0}, 32'd0);
    hold(8'h00, 4);

    // Left held 40 cycles: pulses at t, t+10, t+14 ... t+38
    clear_counts();
    hold(8'h6B, 40); hold(8'h00, 8);
    check_counts("left40", 9, 0, 0, 0, 0, 0);

    // Rotate held 40 cycles: one pulse only
    clear_counts();
    hold(8'h75, 40); hold(8'h00, 8);
    check_counts("rot40", 0, 0, 0, 1, 0, 0);

    // Right released at t+6: a single pulse
    clear_counts();
    hold(8'h74, 10); hold(8'h00, 8);
    check_counts("right_rel", 0, 1, 0, 0, 0, 0);

    // Left switched straight to right while repeating
    clear_counts();
    hold(8'h6B, 20); hold(8'h74, 20); hold(8'h00, 8);
    check_counts("switch", 4, 4, 0, 0, 0, 0);

    // One-cycle glitch never reaches the FSM
    clear_counts();
    hold(8'h6B, 1); hold(8'h00, 10);
    check_counts("glitch", 0, 0, 0, 0, 0, 0);

    // Reset in the middle of DELAY with down held, then held on after
    clear_counts();
    hold(8'h72, 8);
    step(1'b0, 8'h72);
    check_eq("midrst_cmd", {26'd0, out0}, 32'd0);
    check_eq("midrst_act", {31'd0, act0}, 32'd0);
    hold(8'h72, 20); hold(8'h00, 8);
    check_counts("midrst", 0, 0, 5, 0, 0, 0);

    // Player-1 instance ignores the player-0 codes used above
    check_eq("p1_ignored_pulses", p1_pulses, 0);
    check_eq("p1_ignored_active", {31'd0, p1_active_seen}, 32'd0);

    // Randomized keys, hold lengths and occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      r = $urandom_range(0, 13);
      if (r < 12) k = KEYMAP[r / 6][r % 6];
      else if (r == 12) k = 8'h00;
      else k = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) step(1'b0, k);
      hold(k, $urandom_range(1, 30));
    end
    hold(8'h00, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_repeat_ctrl.md
KEY_REPEAT_CTRL -- requirements
Module: key_repeat_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- PLAYER, 0, key map select; 0 = arrows/space/enter, 1 = W/A/S/D/ctrl/shift.
- DAS_CYCLES, 8_000_000, hold delay before auto-repeat starts; legal range 1..2^24-1.
- ARR_CYCLES, 2_500_000, auto-repeat period; legal range 1..2^24-1.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, system clock; the only clock.
- i_rst_n, in, 1, reset; synchronous, active-low.
- i_key, in, 8, held scan code from the PS/2 decoder (0 = none); asynchronous to i_clk.
- o_left, out, 1, move-left command pulse.
- o_right, out, 1, move-right command pulse.
- o_down, out, 1, soft-drop command pulse.
- o_rotate, out, 1, rotate command pulse.
- o_drop, out, 1, hard-drop command pulse.
- o_pause, out, 1, pause command pulse.
- o_active, out, 1, high while a mapped key is held (state not IDLE).

Function
REQ-003 The block SHALL register i_key through three flops (s1, s2, s3).
REQ-004 key_stable SHALL load s2 only when s2 == s3; a code held for fewer than 2 samples SHALL never reach key_stable.
REQ-005 Key map for PLAYER=0 SHALL be: 6B left, 74 right, 72 down, 75 rotate, 29 drop, 5A pause.
REQ-006 Key map for PLAYER=1 SHALL be: 1C left, 23 right, 1B down, 1D rotate, 14 drop, 12 pause.
REQ-007 Any other key_stable value, including 00, SHALL be treated as release.
REQ-008 The FSM SHALL have states IDLE, FIRST, DELAY, REPEAT, HOLD.
REQ-009 IDLE SHALL go to FIRST when key_stable is mapped, and SHALL latch it as cur_code.
REQ-010 FIRST SHALL last one cycle and fire one pulse. It SHALL then go to DELAY (counter = DAS_CYCLES-1) for left/right/down, or to HOLD for rotate/drop/pause.
REQ-011 DELAY SHALL decrement the counter. At 0 it SHALL fire one pulse, load ARR_CYCLES-1 and go to REPEAT.
REQ-012 REPEAT SHALL decrement the counter. At 0 it SHALL fire one pulse and reload ARR_CYCLES-1.
REQ-013 HOLD SHALL fire no pulses.
REQ-014 In DELAY, REPEAT and HOLD, if key_stable != cur_code, the FSM SHALL go to FIRST (new mapped code, which is latched) or to IDLE (release). This check SHALL take priority over the counter reaching 0; no pulse fires for the old code in that cycle.
REQ-015 Command outputs SHALL be registered and mutually exclusive (at most one high per cycle). Each pulse SHALL be exactly one cycle wide.
REQ-016 With edge N being the first i_clk edge that samples a new code into s1, the first pulse SHALL be high in the cycle after edge N+4.
REQ-017 For a held repeatable key, pulse k=1 SHALL occur at the REQ-016 cycle, pulse 2 exactly DAS_CYCLES cycles later, and each later pulse ARR_CYCLES cycles after the previous one.
REQ-018 The down counter SHALL be 24 bits unsigned and SHALL never wrap below 0.

Reset
REQ-019 While i_rst_n=0 at a rising edge, the block SHALL clear: s1..s3, key_stable, cur_code, counter = 0; state = IDLE; all command outputs and o_active = 0.
REQ-020 Reset asserted mid-DELAY or mid-REPEAT SHALL abort with no pulse.
REQ-021 After reset release, a key still held SHALL be treated as a new press (REQ-016 latency).

Structure
REQ-022 Package key_pkg SHALL hold: the twelve scan-code constants, typedef enum cmd_t (CMD_NONE, CMD_LEFT, CMD_RIGHT, CMD_DOWN, CMD_ROTATE, CMD_DROP, CMD_PAUSE), and typedef enum state_t.
REQ-023 The three-flop synchronizer and stability check (REQ-003/004) SHALL be the sub-module key_sync (8-bit in, 8-bit key_stable out). Decode, FSM and counter SHALL remain in key_repeat_ctrl.

Verification (bench uses DAS_CYCLES=10, ARR_CYCLES=4)
REQ-024 PLAYER=0, i_key=6B held 40 cycles: o_left pulses at t, t+10, t+14, t+18, ... (t per REQ-016). No other output pulses. o_active=1 throughout.
REQ-025 PLAYER=0, i_key=75 held 40 cycles: exactly one o_rotate pulse, at t.
REQ-026 i_key=74 held, changed to 00 at t+6: one o_right pulse only. o_active falls 4 cycles after the change.
REQ-027 i_key changed 6B to 74 directly during REPEAT: o_left stops, o_right pulses 4 cycles after the change, then after 10 more cycles.
REQ-028 i_key=6B for 1 cycle, then 00: no pulse. PLAYER=1 with i_key=6B: ignored, o_active=0.
REQ-029 i_rst_n=0 for 1 cycle during DELAY with i_key=72 held: all outputs 0. After release, o_down pulses again after the REQ-016 latency.
